vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Parametrised VGA raster generator driving the 1bpp bitmap display path of the 6502 system.
- Produces hsync/vsync/data-enable with configurable timing, polarity and pixel-clock enable.
- Generates the frame-buffer byte address and bit select for a synchronous (1-cycle read latency) bitmap RAM, with integer pixel scaling and double-buffered page flipping.
- Emits line/frame strobes for the CPU side.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT, 32, horizontal front porch (pixel clocks)
H_PULSE, 88, hsync width
H_BACK, 32, horizontal back porch
V_VISIBLE, 400, active lines
V_FRONT, 8, vertical front porch (lines)
V_PULSE, 5, vsync width
V_BACK, 8, vertical back porch
H_POL, 1, hsync active level
V_POL, 0, vsync active level
CW, 10, counter width; must hold H_TOTAL-1 and V_TOTAL-1
SCALE_LOG2, 1, log2 of pixel replication in x and y
BYTES_PER_LINE, 40, frame-buffer bytes per scaled line
ADDR_W, 14, frame-buffer address width
PAGE1_BASE, 8000, byte base of page 1; page 0 base is 0
FRAME_W, 8, frame counter width

Ports:
clk  in  1  pixel clock domain clock
rst  in  1  asynchronous, active-high reset
ce  in  1  pixel clock enable; all state advances only when ce=1
page_req  in  1  single-cycle request to swap the displayed page
hsync  out  1  horizontal sync, level per H_POL
vsync  out  1  vertical sync, level per V_POL
de  out  1  data enable, high in the visible area
fb_addr  out  ADDR_W  bitmap RAM byte address
pix_sel  out  3  bit index into the returned RAM byte, aligned with de
page  out  1  currently displayed page
frame_cnt  out  FRAME_W  completed-frame counter
line_stb  out  1  one-ce pulse at the start of each line (hc=0)
frame_stb  out  1  one-ce pulse at the start of vertical blanking (vc=V_VISIBLE, hc=0)

Behaviour:
- Totals:
  - H_TOTAL = H_VISIBLE + H_FRONT + H_PULSE + H_BACK (792).
  - V_TOTAL = V_VISIBLE + V_FRONT + V_PULSE + V_BACK (421).
- Counters hc and vc, both CW bits:
  - On ce, hc increments and wraps from H_TOTAL-1 to 0.
  - vc increments only on an hc wrap, and wraps from V_TOTAL-1 to 0.
- Decode from the counters:
  - active = hc<H_VISIBLE && vc<V_VISIBLE.
  - hs_act when hc is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_PULSE-1].
  - vs_act when vc is in the analogous vertical window.
- Pipeline, with a RAM read latency of 1 ce-cycle:
  - Stage 1: fb_addr is registered from the current (hc,vc): page_base + (vc>>SCALE_LOG2)*BYTES_PER_LINE + (hc>>(SCALE_LOG2+3)). It is truncated to ADDR_W.
  - Stage 2: de, hsync, vsync and pix_sel are registered from stage-1 copies. pix_sel = 7 - hc_d[SCALE_LOG2+2:SCALE_LOG2].
  - Net result: RAM data and de/pix_sel/sync are aligned, 2 ce-cycles after the counter.
- Blanking: fb_addr keeps computing during blanking, but de=0. Downstream forces rgb to 0.
- Page flip:
  - page_req sets a pending flag.
  - At the frame wrap (hc=H_TOTAL-1, vc=V_TOTAL-1, ce=1) with the flag set, page toggles and the flag clears.
  - A page_req arriving in the same cycle as the wrap is applied at that wrap.
  - Multiple requests within one frame produce a single toggle.
- frame_cnt increments at every frame wrap and wraps modulo 2^FRAME_W.
- Strobes: line_stb and frame_stb are registered, aligned to stage 2, and high for exactly one ce-enabled cycle. They stay asserted while ce=0.
- ce=0: every register holds its value, with no glitch on any output.
- Reset, asynchronous at any time including mid-line:
  - hc=vc=0, fb_addr=0, pix_sel=7.
  - de=0, line_stb=0, frame_stb=0.
  - hsync=~H_POL, vsync=~V_POL.
  - page=0, pending flag cleared, frame_cnt=0.
  - After release, the pipeline refills; the first valid de occurs 2 ce-cycles after the first ce.

Optional Feature:
- Macro: VGA_TIMING_LINE_IRQ_EN.
- When defined, adds:
  - irq_line in CW
  - irq_ack in 1
  - irq out 1
- irq is a sticky flag:
  - It sets on the line_stb cycle whose line equals irq_line.
  - It clears on irq_ack.
  - If set and ack occur in the same cycle, set wins.
  - It resets to 0.
- When not defined, these ports and the logic do not exist.

Decomposition:
- Package vga_timing_pkg holds:
  - The default modeline constants (640x400 values above).
  - A total() function summing visible+front+pulse+back.
  - localparam helpers for the sync window bounds.
- One natural sub-module: vga_axis_counter, instantiated once per axis.
  - Parameters: visible/front/pulse/back/polarity.
  - Inputs: clk, rst, step.
  - Outputs: count, wrap, active, sync.
  - The vertical instance uses step = ce & horizontal wrap.

Test Plan:
- Reset, then ce=1 for 2 frames -> hsync period is 792 clocks, with 88 clocks at level 1 starting at hc=672. vsync is low for 5 lines starting at line 408. The de count per frame is 256000.
- Visible addressing, page 0 -> at line 0 fb_addr steps 0,1,..,39, one step per 16 clocks. Line 2 restarts at 40, line 399 ends at 7999. pix_sel cycles 7..0, with 2 clocks per value, aligned to de.
- page_req mid-frame, plus a second page_req in the same frame -> page toggles once, exactly at the frame wrap. The next frame's first fb_addr is 8000 and its last is 15999.
- page_req on the wrap cycle itself -> applied at that wrap. frame_cnt increments, and wraps 255->0 after 256 frames.
- ce toggling 1-of-3 cycles -> identical output sequence, stretched 3x. Outputs are stable while ce=0.
- Assert rst mid-line at hc=300 -> all outputs go to their reset values immediately, with hsync=0 and vsync=1. After release, the first de appears 2 ce-cycles later with fb_addr=0. With VGA_TIMING_LINE_IRQ_EN and irq_line=100, irq sets at line 100 and clears on irq_ack.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared modeline defaults and timing helpers for the VGA raster generator.
// Default values describe the 640x400 bitmap mode of the 6502 display path.
package vga_timing_pkg;

  function automatic int unsigned total(input int unsigned visible, input int unsigned front,
                                        input int unsigned pulse, input int unsigned back);
    return visible + front + pulse + back;
  endfunction

  function automatic int unsigned sync_start(input int unsigned visible,
                                             input int unsigned front);
    return visible + front;
  endfunction

  function automatic int unsigned sync_end(input int unsigned visible, input int unsigned front,
                                           input int unsigned pulse);
    return visible + front + pulse - 1;
  endfunction

  localparam int unsigned DefHVisible     = 640;
  localparam int unsigned DefHFront       = 32;
  localparam int unsigned DefHPulse       = 88;
  localparam int unsigned DefHBack        = 32;
  localparam int unsigned DefVVisible     = 400;
  localparam int unsigned DefVFront       = 8;
  localparam int unsigned DefVPulse       = 5;
  localparam int unsigned DefVBack        = 8;
  localparam logic        DefHPol         = 1'b1;
  localparam logic        DefVPol         = 1'b0;
  localparam int unsigned DefCw           = 10;
  localparam int unsigned DefScaleLog2    = 1;
  localparam int unsigned DefBytesPerLine = 40;
  localparam int unsigned DefAddrW        = 14;
  localparam int unsigned DefPage1Base    = 8000;
  localparam int unsigned DefFrameW       = 8;

  localparam int unsigned DefHTotal     = total(DefHVisible, DefHFront, DefHPulse, DefHBack);
  localparam int unsigned DefVTotal     = total(DefVVisible, DefVFront, DefVPulse, DefVBack);
  localparam int unsigned DefHSyncStart = sync_start(DefHVisible, DefHFront);
  localparam int unsigned DefHSyncEnd   = sync_end(DefHVisible, DefHFront, DefHPulse);
  localparam int unsigned DefVSyncStart = sync_start(DefVVisible, DefVFront);
  localparam int unsigned DefVSyncEnd   = sync_end(DefVVisible, DefVFront, DefVPulse);

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with visible-area and sync-window decode.
// Outputs are combinational from the count; sync is already at the configured polarity.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned Visible  = DefHVisible,
  parameter int unsigned Front    = DefHFront,
  parameter int unsigned Pulse    = DefHPulse,
  parameter int unsigned Back     = DefHBack,
  parameter logic        Polarity = DefHPol,
  parameter int unsigned Cw       = DefCw
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step,
  output logic [Cw-1:0] count,
  output logic          wrap,
  output logic          active,
  output logic          sync
);

  localparam int unsigned Total  = total(Visible, Front, Pulse, Back);
  localparam int unsigned SyncLo = sync_start(Visible, Front);
  localparam int unsigned SyncHi = sync_end(Visible, Front, Pulse);

  logic [Cw-1:0] count_q, count_d;
  logic          in_window;

  always_comb begin
    wrap      = (count_q == Cw'(Total - 1));
    count_d   = count_q;
    if (step) begin
      count_d = wrap ? '0 : count_q + 1'b1;
    end
    active    = (count_q < Cw'(Visible));
    in_window = (count_q >= Cw'(SyncLo)) && (count_q <= Cw'(SyncHi));
    sync      = in_window ? Polarity : ~Polarity;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator for a 1bpp bitmap behind a 1-cycle synchronous RAM, with page flipping.
// Optional per-line interrupt is built when VGA_TIMING_LINE_IRQ_EN is defined.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE      = DefHVisible,
  parameter int unsigned H_FRONT        = DefHFront,
  parameter int unsigned H_PULSE        = DefHPulse,
  parameter int unsigned H_BACK         = DefHBack,
  parameter int unsigned V_VISIBLE      = DefVVisible,
  parameter int unsigned V_FRONT        = DefVFront,
  parameter int unsigned V_PULSE        = DefVPulse,
  parameter int unsigned V_BACK         = DefVBack,
  parameter logic        H_POL          = DefHPol,
  parameter logic        V_POL          = DefVPol,
  parameter int unsigned CW             = DefCw,
  parameter int unsigned SCALE_LOG2     = DefScaleLog2,
  parameter int unsigned BYTES_PER_LINE = DefBytesPerLine,
  parameter int unsigned ADDR_W         = DefAddrW,
  parameter int unsigned PAGE1_BASE     = DefPage1Base,
  parameter int unsigned FRAME_W        = DefFrameW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic               page_req,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [2:0]         pix_sel,
  output logic               page,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic               line_stb,
`ifdef VGA_TIMING_LINE_IRQ_EN
  input  logic [CW-1:0]      irq_line,
  input  logic               irq_ack,
  output logic               irq,
`endif
  output logic               frame_stb
);

  logic [CW-1:0] hc, vc;
  logic          h_wrap, v_wrap, h_active, v_active, h_sync, v_sync;
  logic          v_step, frame_wrap;

  vga_axis_counter #(
    .Visible (H_VISIBLE),
    .Front   (H_FRONT),
    .Pulse   (H_PULSE),
    .Back    (H_BACK),
    .Polarity(H_POL),
    .Cw      (CW)
  ) u_h_axis (
    .clk   (clk),
    .rst   (rst),
    .step  (ce),
    .count (hc),
    .wrap  (h_wrap),
    .active(h_active),
    .sync  (h_sync)
  );

  assign v_step     = ce & h_wrap;
  assign frame_wrap = v_step & v_wrap;

  vga_axis_counter #(
    .Visible (V_VISIBLE),
    .Front   (V_FRONT),
    .Pulse   (V_PULSE),
    .Back    (V_BACK),
    .Polarity(V_POL),
    .Cw      (CW)
  ) u_v_axis (
    .clk   (clk),
    .rst   (rst),
    .step  (v_step),
    .count (vc),
    .wrap  (v_wrap),
    .active(v_active),
    .sync  (v_sync)
  );

  // Stage 1: RAM address plus copies of the decode that must line up with the read data.
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic              act_s1_q, hs_s1_q, vs_s1_q, line_s1_q, frame_s1_q;
  logic [2:0]        bit_s1_q;
  // Stage 2: outputs aligned with the RAM data.
  logic              de_q, hsync_q, vsync_q, line_stb_q, frame_stb_q;
  logic [2:0]        pix_sel_q;
  // Page flip and frame bookkeeping.
  logic              page_q, page_d, pending_q, pending_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    fb_addr_d = ADDR_W'((page_q ? 32'(PAGE1_BASE) : 32'd0)
                        + (32'(vc) >> SCALE_LOG2) * 32'(BYTES_PER_LINE)
                        + (32'(hc) >> (SCALE_LOG2 + 3)));
  end

  // A request seen on the wrap cycle itself is folded into that wrap.
  always_comb begin
    page_d      = page_q;
    pending_d   = pending_q;
    frame_cnt_d = frame_cnt_q;
    if (frame_wrap) begin
      page_d      = page_q ^ (pending_q | page_req);
      pending_d   = 1'b0;
      frame_cnt_d = frame_cnt_q + 1'b1;
    end else if (ce && page_req) begin
      pending_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_addr_q   <= '0;
      act_s1_q    <= 1'b0;
      hs_s1_q     <= ~H_POL;
      vs_s1_q     <= ~V_POL;
      bit_s1_q    <= 3'd0;
      line_s1_q   <= 1'b0;
      frame_s1_q  <= 1'b0;
      de_q        <= 1'b0;
      hsync_q     <= ~H_POL;
      vsync_q     <= ~V_POL;
      pix_sel_q   <= 3'd7;
      line_stb_q  <= 1'b0;
      frame_stb_q <= 1'b0;
    end else if (ce) begin
      fb_addr_q   <= fb_addr_d;
      act_s1_q    <= h_active & v_active;
      hs_s1_q     <= h_sync;
      vs_s1_q     <= v_sync;
      bit_s1_q    <= hc[SCALE_LOG2+2 -: 3];
      line_s1_q   <= (hc == '0);
      frame_s1_q  <= (hc == '0) && (vc == CW'(V_VISIBLE));
      de_q        <= act_s1_q;
      hsync_q     <= hs_s1_q;
      vsync_q     <= vs_s1_q;
      pix_sel_q   <= 3'd7 - bit_s1_q;
      line_stb_q  <= line_s1_q;
      frame_stb_q <= frame_s1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      page_q      <= 1'b0;
      pending_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      page_q      <= page_d;
      pending_q   <= pending_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign fb_addr   = fb_addr_q;
  assign de        = de_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign pix_sel   = pix_sel_q;
  assign line_stb  = line_stb_q;
  assign frame_stb = frame_stb_q;
  assign page      = page_q;
  assign frame_cnt = frame_cnt_q;

`ifdef VGA_TIMING_LINE_IRQ_EN
  // hc==1 is the counter state whose ce edge raises line_stb for the line at hc==0.
  logic irq_q, irq_d, irq_set;

  always_comb begin
    irq_set = ce && (hc == CW'(1)) && (vc == irq_line);
    irq_d   = irq_q;
    if (irq_set) begin
      irq_d = 1'b1;
    end else if (ce && irq_ack) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen on a shrunken modeline, checked against an
// arithmetic raster model driven by the number of ce edges since reset.
module tb_vga_timing_gen;

  localparam int unsigned HV = 32, HF = 4, HP = 6, HB = 6;
  localparam int unsigned VV = 12, VF = 2, VP = 3, VB = 2;
  localparam int unsigned HT = HV + HF + HP + HB;
  localparam int unsigned VT = VV + VF + VP + VB;
  localparam int unsigned FT = HT * VT;
  localparam int unsigned SCL = 1, BPL = 2, AW = 14, PAGE1 = 100, FW = 3, CWB = 10;
  localparam int unsigned IRQ_LINE = 5;

  logic          clk = 1'b0;
  logic          rst, ce, page_req;
  logic          hsync, vsync, de, page, line_stb, frame_stb;
  logic [AW-1:0] fb_addr;
  logic [2:0]    pix_sel;
  logic [FW-1:0] frame_cnt;
`ifdef VGA_TIMING_LINE_IRQ_EN
  logic [CWB-1:0] irq_line;
  logic           irq_ack, irq;
`endif

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_PULSE(HP), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_PULSE(VP), .V_BACK(VB),
    .H_POL(1'b1), .V_POL(1'b0), .CW(CWB), .SCALE_LOG2(SCL),
    .BYTES_PER_LINE(BPL), .ADDR_W(AW), .PAGE1_BASE(PAGE1), .FRAME_W(FW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .page_req (page_req),
    .hsync    (hsync),
    .vsync    (vsync),
    .de       (de),
    .fb_addr  (fb_addr),
    .pix_sel  (pix_sel),
    .page     (page),
    .frame_cnt(frame_cnt),
    .line_stb (line_stb),
`ifdef VGA_TIMING_LINE_IRQ_EN
    .irq_line (irq_line),
    .irq_ack  (irq_ack),
    .irq      (irq),
`endif
    .frame_stb(frame_stb)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned n;          // ce edges since reset release = raster position
  logic        pend_m;
  logic        page_hist[$]; // page in effect during frame k
  logic        irq_m;
  int unsigned de_seen = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (ce count %0d)", tag, act, exp, n);
    end
  endtask

  task automatic model_reset();
    n      = 0;
    pend_m = 1'b0;
    page_hist.delete();
    page_hist.push_back(1'b0);
    irq_m  = 1'b0;
  endtask

  task automatic check_all();
    int unsigned q, hc, vc, exp_addr;
    logic e_de, e_hs, e_vs, e_ls, e_fs;
    logic [2:0] e_pix;
    exp_addr = 0;
    if (n != 0) begin
      q  = n - 1;
      hc = q % HT;
      vc = (q / HT) % VT;
      exp_addr = (page_hist[q / FT] ? PAGE1 : 0) + (vc >> SCL) * BPL + (hc >> (SCL + 3));
      exp_addr = exp_addr % (1 << AW);
    end
    check_eq("fb_addr", 32'(fb_addr), exp_addr);
    check_eq("page", 32'(page), 32'(page_hist[n / FT]));
    check_eq("frame_cnt", 32'(frame_cnt), (n / FT) % (1 << FW));
    if (n < 2) begin
      e_de = 1'b0; e_hs = 1'b0; e_vs = 1'b1; e_pix = 3'd7; e_ls = 1'b0; e_fs = 1'b0;
    end else begin
      q     = n - 2;
      hc    = q % HT;
      vc    = (q / HT) % VT;
      e_de  = (hc < HV) && (vc < VV);
      e_hs  = (hc >= HV + HF) && (hc < HV + HF + HP);
      e_vs  = !((vc >= VV + VF) && (vc < VV + VF + VP));
      e_pix = 3'(7 - ((hc >> SCL) % 8));
      e_ls  = (hc == 0);
      e_fs  = (hc == 0) && (vc == VV);
    end
    check_eq("de", 32'(de), 32'(e_de));
    check_eq("hsync", 32'(hsync), 32'(e_hs));
    check_eq("vsync", 32'(vsync), 32'(e_vs));
    check_eq("pix_sel", 32'(pix_sel), 32'(e_pix));
    check_eq("line_stb", 32'(line_stb), 32'(e_ls));
    check_eq("frame_stb", 32'(frame_stb), 32'(e_fs));
`ifdef VGA_TIMING_LINE_IRQ_EN
    check_eq("irq", 32'(irq), 32'(irq_m));
`endif
  endtask

  task automatic step(input logic ce_v, input logic req_v, input logic ack_v);
    int unsigned q;
    ce       = ce_v;
    page_req = req_v;
`ifdef VGA_TIMING_LINE_IRQ_EN
    irq_ack  = ack_v;
`endif
    @(posedge clk);
    if (ce_v) begin
      if (n % FT == FT - 1) begin
        page_hist.push_back(page_hist[page_hist.size() - 1] ^ (pend_m | req_v));
        pend_m = 1'b0;
      end else if (req_v) begin
        pend_m = 1'b1;
      end
      n++;
      q = n - 2;
      if (n >= 2 && (q % HT) == 0 && ((q / HT) % VT) == IRQ_LINE) irq_m = 1'b1;
      else if (ack_v) irq_m = 1'b0;
    end
    #1;
    check_all();
    if (ce_v && de && n >= FT + 2 && n < 2 * FT + 2) de_seen++;
  endtask

  initial begin
    logic req, ack, cev;
    rst      = 1'b1;
    ce       = 1'b0;
    page_req = 1'b0;
`ifdef VGA_TIMING_LINE_IRQ_EN
    irq_line = CWB'(IRQ_LINE);
    irq_ack  = 1'b0;
`endif
    model_reset();
    #12;
    check_all();
    rst = 1'b0;

    // Free-running ce: two requests in frame 1, one on the wrap cycle of frame 2.
    for (int i = 0; i < 8 * FT + 100; i++) begin
      req = ((n / FT) != 2) && ($urandom_range(0, 1999) == 0);
      if (n == FT + 100 || n == FT + 300 || n == 3 * FT - 1) req = 1'b1;
      ack = ($urandom_range(0, 39) == 0);
      step(1'b1, req, ack);
    end
    check_eq("de_per_frame", de_seen, HV * VV);

    // ce one cycle in three.
    for (int i = 0; i < 6 * FT; i++) begin
      cev = ((i % 3) == 0);
      req = cev && ($urandom_range(0, 499) == 0);
      ack = cev && ($urandom_range(0, 39) == 0);
      step(cev, req, ack);
    end

    // Random ce.
    for (int i = 0; i < 1500; i++) begin
      cev = 1'($urandom_range(0, 1));
      req = cev && ($urandom_range(0, 299) == 0);
      ack = cev && ($urandom_range(0, 39) == 0);
      step(cev, req, ack);
    end

    // Asynchronous reset in the middle of a visible line.
    while ((n % HT) != 20) step(1'b1, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_all();
    end
    #2;
    rst = 1'b0;
    for (int i = 0; i < 2 * FT + 50; i++) begin
      ack = ($urandom_range(0, 39) == 0);
      step(1'b1, 1'b0, ack);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
